// File: rtl/shift_reg_sequencer.sv
// Sequencer for an external parallel/serial shift register: TX loads a word and shifts it out
// LSB first; RX shifts NBITS serial bits in and captures the resulting word.
module shift_reg_sequencer #(
    parameter int NBITS      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [NBITS-1:0] data_in,
    input  logic             ser_in,
    input  logic [NBITS-1:0] reg_q,
    output logic             reg_load,
    output logic             reg_shift,
    output logic             reg_serial,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] data_out
);

    localparam int BW = $clog2(NBITS + 1);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          mode_r;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic          bit_end;

    assign bit_end = (cyc_cnt == CYC_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = mode ? SHIFT : LOAD;
            LOAD:    state_nxt = abort ? IDLE : SHIFT;
            SHIFT: begin
                if (abort)
                    state_nxt = IDLE;
                else if (bit_end && bit_cnt == LAST_BIT)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        mode_r  <= mode;
                        bit_cnt <= '0;
                        cyc_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        if (bit_end) begin
                            cyc_cnt <= '0;
                            bit_cnt <= bit_cnt + BW'(1);
                        end else begin
                            cyc_cnt <= cyc_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!abort && mode_r)
                        data_out <= reg_q;
                end
                default: ;
            endcase
        end
    end

    // Abort suppresses register strobes and the done pulse in the same cycle it is seen.
    assign reg_load   = (state == LOAD) && !abort;
    assign reg_shift  = (state == SHIFT) && bit_end && !abort;
    assign reg_serial = mode_r ? ser_in : 1'b0;
    assign ser_out    = ((state == SHIFT) && !mode_r) ? reg_q[0] : 1'b0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE) && !abort;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: two instances (BIT_CYCLES=1 and 3), each with a behavioural shift register.
module tb_shift_reg_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_w   [2];
    logic       mode_w    [2];
    logic       abort_w   [2];
    logic       ser_in_w  [2];
    logic [3:0] data_in_w [2];
    logic [3:0] reg_q_w   [2];
    logic       reg_load_w  [2];
    logic       reg_shift_w [2];
    logic       reg_serial_w[2];
    logic       ser_out_w   [2];
    logic       busy_w      [2];
    logic       done_w      [2];
    logic [3:0] data_out_w  [2];

    logic [3:0] exp_dout [2];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [3:0] q;
        shift_reg_sequencer #(.NBITS(4), .BIT_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk_2(clk), .reset(reset), .start(start_w[g]), .mode(mode_w[g]),
            .abort(abort_w[g]), .data_in(data_in_w[g]), .ser_in(ser_in_w[g]),
            .reg_q(reg_q_w[g]), .reg_load(reg_load_w[g]), .reg_shift(reg_shift_w[g]),
            .reg_serial(reg_serial_w[g]), .ser_out(ser_out_w[g]), .busy(busy_w[g]),
            .done(done_w[g]), .data_out(data_out_w[g])
        );
        always_ff @(posedge clk) begin
            if (reg_load_w[g])
                q <= data_in_w[g];
            else if (reg_shift_w[g])
                q <= {reg_serial_w[g], q[3:1]};
        end
        assign reg_q_w[g] = q;
    end

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int i, logic st, logic md, logic ab, logic si, logic [3:0] di);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            start_w[j] = 1'b0; mode_w[j] = 1'b0; abort_w[j] = 1'b0;
            ser_in_w[j] = 1'b0; data_in_w[j] = 4'h0;
        end
        start_w[i] = st; mode_w[i] = md; abort_w[i] = ab; ser_in_w[i] = si; data_in_w[i] = di;
        #1;
    endtask

    task automatic idle_chk(int i, string tag);
        chk({tag, ".busy"},  busy_w[i],      4'h0);
        chk({tag, ".done"},  done_w[i],      4'h0);
        chk({tag, ".load"},  reg_load_w[i],  4'h0);
        chk({tag, ".shift"}, reg_shift_w[i], 4'h0);
        chk({tag, ".ser"},   ser_out_w[i],   4'h0);
        chk({tag, ".dout"},  data_out_w[i],  exp_dout[i]);
    endtask

    // Expected timeline from start: TX has one load cycle then NBITS*bc shift cycles then done;
    // RX goes straight to the shift cycles. abort_at = cycle index (0 = with start), -1 = none.
    task automatic xfer(int i, logic m, logic [3:0] word, int abort_at);
        int bc, n, first, ph;
        logic in_sh, sh_cyc, ab, si;
        bc    = (i == 0) ? 1 : 3;
        n     = m ? 4 * bc + 1 : 4 * bc + 2;
        first = m ? 1 : 2;
        drive(i, 1'b1, m, abort_at == 0, 1'($urandom), word);
        idle_chk(i, "start");
        if (abort_at == 0) begin
            drive(i, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
            idle_chk(i, "start_abort");
            return;
        end
        for (int k = 1; k <= n; k++) begin
            ph     = k - first;
            in_sh  = (ph >= 0) && (ph < 4 * bc);
            sh_cyc = in_sh && (ph % bc == bc - 1);
            ab     = (k == abort_at);
            si     = (m && sh_cyc) ? word[ph / bc] : 1'($urandom);
            drive(i, 1'($urandom), 1'($urandom), ab, si, (k == 1) ? word : 4'($urandom));
            chk("load",  reg_load_w[i],  {3'b0, !m && k == 1 && !ab});
            chk("shift", reg_shift_w[i], {3'b0, sh_cyc && !ab});
            chk("ser",   ser_out_w[i],   {3'b0, (!m && in_sh) ? word[ph / bc] : 1'b0});
            chk("busy",  busy_w[i],      4'h1);
            chk("done",  done_w[i],      {3'b0, k == n && !ab});
            chk("dout",  data_out_w[i],  exp_dout[i]);
            if (ab) begin
                drive(i, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
                idle_chk(i, "after_abort");
                return;
            end
        end
        if (m) exp_dout[i] = word;
        drive(i, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        idle_chk(i, "after_done");
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            start_w[j] = 1'b0; abort_w[j] = 1'b0;
        end
        repeat (cycles) @(negedge clk);
        #1;
        exp_dout[0] = 4'h0;
        exp_dout[1] = 4'h0;
        idle_chk(0, "in_reset0");
        idle_chk(1, "in_reset1");
        reset = 1'b0;
    endtask

    initial begin
        int i, n, ab;
        logic m;
        logic [3:0] w;
        reset = 1'b0;
        for (int j = 0; j < 2; j++) begin
            start_w[j] = 1'b0; mode_w[j] = 1'b0; abort_w[j] = 1'b0;
            ser_in_w[j] = 1'b0; data_in_w[j] = 4'h0; exp_dout[j] = 4'h0;
        end
        do_reset(2);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        idle_chk(0, "reset0");
        idle_chk(1, "reset1");

        xfer(0, 1'b0, 4'b1011, -1);
        xfer(0, 1'b1, 4'h6, -1);
        xfer(1, 1'b0, 4'b0101, -1);
        xfer(0, 1'b0, 4'b1110, 3);
        xfer(1, 1'b0, 4'b0110, 6);
        xfer(1, 1'b1, 4'h9, 13);
        xfer(0, 1'b1, 4'hC, 1);
        xfer(0, 1'b0, 4'h3, 0);
        xfer(0, 1'b1, 4'hA, -1);
        xfer(0, 1'b0, 4'h5, -1);
        xfer(1, 1'b1, 4'h3, -1);
        xfer(1, 1'b0, 4'hC, -1);

        // Reset while instance 1 is mid-SHIFT.
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7);
        repeat (4) drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("mid_busy", busy_w[1], 4'h1);
        do_reset(2);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        idle_chk(1, "post_reset");
        xfer(1, 1'b0, 4'hD, -1);

        for (int r = 0; r < 24; r++) begin
            i  = int'($urandom_range(0, 1));
            m  = 1'($urandom);
            w  = 4'($urandom);
            n  = m ? ((i == 0) ? 5 : 13) : ((i == 0) ? 6 : 14);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            xfer(i, m, w, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
